// File: rtl/execute_writeback_if.sv
// Bundle of the operand hand-off from the load stage and the write-back/status signals.
// The master side is the controller/load stage; the slave side is execute_writeback.
interface execute_writeback_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 6
);
    logic                  ready;
    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [AW-1:0]         dst;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  overflow;
    logic                  busy;
    logic                  done;
    logic                  drop_err;

    modport master (
        output ready, opcode, src1, src2, dst,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, overflow, busy, done, drop_err
    );

    modport slave (
        input  ready, opcode, src1, src2, dst,
        output mem_wr_en, mem_wr_addr, mem_wr_data, overflow, busy, done, drop_err
    );
endinterface

// File: rtl/execute_writeback.sv
// Execute/write-back stage: ADD/SUB/MOV in one cycle, MUL by iterative shift-add.
// Optional macro EXEC_SATURATE_EN clamps overflowing results instead of wrapping them.
module execute_writeback #(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_MEMORY_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    execute_writeback_if.slave    bus
);
    localparam int AW = $clog2(DATA_MEMORY_SIZE);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e                    state_q,   state_d;
    logic [1:0]                op_q,      op_d;
    logic [DATA_WIDTH-1:0]     a_q,       a_d;
    logic [DATA_WIDTH-1:0]     b_q,       b_d;
    logic [AW-1:0]             dst_q,     dst_d;
    logic [2*DATA_WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]             cnt_q,     cnt_d;
    logic                      wr_en_q,   wr_en_d;
    logic [AW-1:0]             wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      ovf_q,     ovf_d;
    logic                      busy_q,    busy_d;
    logic                      done_q,    done_d;
    logic                      drop_q,    drop_d;

    logic [DATA_WIDTH:0]       sum_s;
    logic [DATA_WIDTH:0]       diff_s;
    logic [2*DATA_WIDTH-1:0]   partial_s;
    logic [2*DATA_WIDTH-1:0]   prod_s;
    logic [DATA_WIDTH-1:0]     wrap_s;
    logic [DATA_WIDTH-1:0]     res_s;
    logic                      ovf_s;

    // Datapath: arithmetic on the latched operands and the shift-add step.
    always_comb begin
        sum_s  = {1'b0, a_q} + {1'b0, b_q};
        diff_s = {1'b0, a_q} - {1'b0, b_q};
        if (b_q[cnt_q]) begin
            partial_s = {{DATA_WIDTH{1'b0}}, a_q} << cnt_q;
        end else begin
            partial_s = {(2*DATA_WIDTH){1'b0}};
        end
        // On the last iteration this sum is the full product.
        prod_s = acc_q + partial_s;
    end

    // Result and overflow selection for the latched opcode.
    always_comb begin
        wrap_s = a_q;
        ovf_s  = 1'b0;
        case (op_q)
            OP_ADD: begin
                wrap_s = sum_s[DATA_WIDTH-1:0];
                ovf_s  = sum_s[DATA_WIDTH];
            end
            OP_SUB: begin
                wrap_s = diff_s[DATA_WIDTH-1:0];
                ovf_s  = diff_s[DATA_WIDTH];
            end
            OP_MUL: begin
                wrap_s = prod_s[DATA_WIDTH-1:0];
                ovf_s  = |prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_MOV: begin
                wrap_s = a_q;
                ovf_s  = 1'b0;
            end
            default: begin
                wrap_s = a_q;
                ovf_s  = 1'b0;
            end
        endcase
    end

    // Write-data shaping: wrap by default, clamp toward the overflowed bound when enabled.
    always_comb begin
        res_s = wrap_s;
`ifdef EXEC_SATURATE_EN
        if (ovf_s) begin
            if (op_q == OP_SUB) begin
                res_s = {DATA_WIDTH{1'b0}};
            end else begin
                res_s = {DATA_WIDTH{1'b1}};
            end
        end else begin
            res_s = wrap_s;
        end
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = done_q;
        drop_d    = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ready) begin
                    op_d    = bus.opcode;
                    a_d     = bus.src1;
                    b_d     = bus.src2;
                    dst_d   = bus.dst;
                    acc_d   = {(2*DATA_WIDTH){1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (bus.ready) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if ((op_q != OP_MUL) || (cnt_q == CNT_LAST)) begin
                    wr_en_d   = 1'b1;
                    done_d    = 1'b1;
                    wr_addr_d = dst_q;
                    wr_data_d = res_s;
                    ovf_d     = ovf_s;
                    state_d   = ST_WRITE;
                end else begin
                    acc_d = prod_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                // The write cycle still counts as busy, so a pulse here is dropped.
                if (bus.ready) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                wr_en_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                wr_en_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            a_q       <= {DATA_WIDTH{1'b0}};
            b_q       <= {DATA_WIDTH{1'b0}};
            dst_q     <= {AW{1'b0}};
            acc_q     <= {(2*DATA_WIDTH){1'b0}};
            cnt_q     <= {CW{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {DATA_WIDTH{1'b0}};
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dst_q     <= dst_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.drop_err    = drop_q;
endmodule

// File: tb/tb_execute_writeback.sv
// Directed bench for execute_writeback: hand-computed results for each opcode, drop and reset cases.
// Expected data switches to clamped values when EXEC_SATURATE_EN is defined.
module tb_execute_writeback;
    localparam int DW = 8;
    localparam int AW = 6;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;
    int   seen;

    execute_writeback_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    execute_writeback #(.DATA_WIDTH(DW), .DATA_MEMORY_SIZE(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle ready pulse; returns at the negedge after the capture edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [5:0] d);
        bus.ready  = 1'b1;
        bus.opcode = op;
        bus.src1   = a;
        bus.src2   = b;
        bus.dst    = d;
        @(negedge clk);
        bus.ready  = 1'b0;
    endtask

    // Count negedges until mem_wr_en is seen, starting from a given cycle offset.
    task automatic wait_wr(input int start, output int cycles);
        cycles = start;
        while (bus.mem_wr_en !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_write(input string tag, input int exp_lat, input logic [5:0] a,
                               input logic [7:0] d, input logic o);
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_wren"}, 32'(bus.mem_wr_en), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_wr_addr), 32'(a));
        chk({tag, "_data"}, 32'(bus.mem_wr_data), 32'(d));
        chk({tag, "_ovf"},  32'(bus.overflow), 32'(o));
        @(negedge clk);
        chk({tag, "_wren_off"}, 32'(bus.mem_wr_en), 32'd0);
        chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, "_data_hold"}, 32'(bus.mem_wr_data), 32'(d));
        chk({tag, "_ovf_hold"}, 32'(bus.overflow), 32'(o));
    endtask

    logic [7:0] add_exp, sub_exp, mul2_exp;

    initial begin
        total = 0;
        bad   = 0;
`ifdef EXEC_SATURATE_EN
        add_exp  = 8'd255;
        sub_exp  = 8'd0;
        mul2_exp = 8'd255;
`else
        add_exp  = 8'd44;
        sub_exp  = 8'd252;
        mul2_exp = 8'd0;
`endif
        rst_n = 1'b0;
        bus.ready = 1'b0; bus.opcode = 2'b00; bus.src1 = 8'd0; bus.src2 = 8'd0; bus.dst = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_wren", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", 32'(bus.mem_wr_data), 32'd0);
        chk("rst_drop", 32'(bus.drop_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with carry
        issue(2'b00, 8'd200, 8'd100, 6'd5);
        chk("add_busy", 32'(bus.busy), 32'd1);
        wait_wr(0, lat);
        check_write("add", 1, 6'd5, add_exp, 1'b1);

        // SUB with borrow, then without
        issue(2'b01, 8'd5, 8'd9, 6'd63);
        wait_wr(0, lat);
        check_write("sub_borrow", 1, 6'd63, sub_exp, 1'b1);
        issue(2'b01, 8'd9, 8'd5, 6'd10);
        wait_wr(0, lat);
        check_write("sub", 1, 6'd10, 8'd4, 1'b0);

        // MUL without and with overflow
        issue(2'b10, 8'd15, 8'd17, 6'd20);
        wait_wr(0, lat);
        check_write("mul", 8, 6'd20, 8'd255, 1'b0);
        issue(2'b10, 8'd16, 8'd16, 6'd21);
        wait_wr(0, lat);
        check_write("mul_ovf", 8, 6'd21, mul2_exp, 1'b1);

        // MOV ignores src2
        issue(2'b11, 8'hA5, 8'h3C, 6'd7);
        wait_wr(0, lat);
        check_write("mov", 1, 6'd7, 8'hA5, 1'b0);
        chk("drop_clear", 32'(bus.drop_err), 32'd0);

        // Second ready pulse three cycles into a MUL is dropped
        issue(2'b10, 8'd13, 8'd11, 6'd30);
        repeat (2) @(negedge clk);
        issue(2'b00, 8'd1, 8'd2, 6'd9);
        chk("drop_flag", 32'(bus.drop_err), 32'd1);
        wait_wr(3, lat);
        check_write("drop_mul", 8, 6'd30, 8'd143, 1'b0);
        @(negedge clk);
        chk("drop_no_extra", 32'(bus.mem_wr_en), 32'd0);
        chk("drop_sticky", 32'(bus.drop_err), 32'd1);

        // Reset three cycles into a MUL aborts it
        issue(2'b10, 8'd3, 8'd3, 6'd40);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_drop", 32'(bus.drop_err), 32'd0);
        chk("mrst_addr", 32'(bus.mem_wr_addr), 32'd0);
        chk("mrst_data", 32'(bus.mem_wr_data), 32'd0);
        chk("mrst_ovf", 32'(bus.overflow), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en === 1'b1) seen++;
        end
        chk("mrst_no_write", 32'(seen), 32'd0);
        issue(2'b00, 8'd1, 8'd1, 6'd2);
        wait_wr(0, lat);
        check_write("post_rst_add", 1, 6'd2, 8'd2, 1'b0);

        // Ready coincident with reset is not accepted
        bus.ready = 1'b1; bus.opcode = 2'b11; bus.src1 = 8'd77; bus.dst = 6'd3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready = 1'b0;
        chk("rst_ready_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en === 1'b1) seen++;
        end
        chk("rst_ready_no_write", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
- Downstream of the operand-load stage.
- Consumes the load stage's one-cycle ready pulse, together with opcode, two operand values and destination address.
- Computes the result (add/sub/single-cycle; mul/iterative shift-add; mov) and writes it back to data memory through a single-cycle write strobe.
- Signals busy so the controller can hold off the load stage's enable until the block is free.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits.
- DATA_MEMORY_SIZE, 64, data memory depth; address width AW = $clog2(DATA_MEMORY_SIZE).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- ready  input  1  load stage operands valid (one-cycle pulse).
- opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 MOV.
- src1  input  DATA_WIDTH  operand A.
- src2  input  DATA_WIDTH  operand B.
- dst  input  AW  write-back address.
- mem_wr_en  output  1  data memory write strobe.
- mem_wr_addr  output  AW  write address.
- mem_wr_data  output  DATA_WIDTH  write data.
- overflow  output  1  status of the last written result, valid while mem_wr_en=1 and held afterwards.
- busy  output  1  block is occupied; upstream must not pulse ready.
- done  output  1  one-cycle pulse, coincident with mem_wr_en.
- drop_err  output  1  sticky flag: a ready pulse arrived while busy.

Behaviour:
- All outputs are registered.
- Reset: rst_n low at a clk edge sets state=IDLE and clears every output and internal register to 0 (including drop_err). Reset takes priority over every other event.
- Reset mid-operation aborts the in-flight instruction; no write occurs.
- States: IDLE, EXEC, WRITE.
- IDLE, ready=1 at edge N:
  - latch opcode, src1, src2, dst;
  - busy<=1; state<=EXEC;
  - for MUL: clear accumulator and iteration counter.
- EXEC, ADD/SUB/MOV, one cycle. At edge N+1: state<=WRITE, mem_wr_en<=1, done<=1, result, address and overflow loaded.
- EXEC, MUL, shift-add over the multiplier bits, DATA_WIDTH cycles:
  - 2*DATA_WIDTH-bit accumulator; counter counts 0..DATA_WIDTH-1.
  - At the edge where counter=DATA_WIDTH-1, transition as above.
  - mem_wr_en therefore rises at edge N+DATA_WIDTH.
- WRITE, one cycle. At the next edge: mem_wr_en<=0, done<=0, busy<=0, state<=IDLE.
  - A ready in this cycle is treated as busy (dropped); the next instruction may be accepted from the following cycle.
- Arithmetic is unsigned. The result is the low DATA_WIDTH bits.
- overflow per opcode:
  - ADD: carry out.
  - SUB: borrow (src1 < src2).
  - MUL: any upper DATA_WIDTH bits nonzero.
  - MOV: result=src1, overflow=0.
- ready while busy=1 (EXEC or WRITE):
  - the pulse is ignored; the latched instruction is unaffected;
  - drop_err<=1 and stays set until reset.
- ready and rst_n low at the same edge: reset wins; the instruction is not accepted.
- mem_wr_addr, mem_wr_data and overflow hold their last values after the write; only mem_wr_en and done return to 0.
- dst uses the full AW range; no address wrap or check is performed.

Optional Feature:
- Macro: EXEC_SATURATE_EN.
- Defined: an overflowing result is clamped instead of wrapped, and the overflow flag is still reported.
  - ADD carry and MUL overflow write all ones.
  - SUB borrow writes 0.
- Undefined: results wrap modulo 2^DATA_WIDTH.
- Timing and ports are identical in both builds.

Test Plan:
- ADD: reset, then ready with opcode=00, src1=200, src2=100, dst=5 -> at edge N+1: mem_wr_en=1, addr=5, data=44, overflow=1, done=1 for one cycle, busy=0 after. With EXEC_SATURATE_EN: data=255.
- SUB: opcode=01, src1=5, src2=9, dst=63 -> data=252, overflow=1 (saturated build: 0). Then src1=9, src2=5 -> data=4, overflow=0.
- MUL: opcode=10, 15*17 -> data=255, overflow=0, mem_wr_en rises exactly 8 cycles after the capture edge. Then 16*16 -> data=0, overflow=1 (saturated build: 255).
- MOV: opcode=11, src1=0xA5, src2=0x3C, dst=7 -> data=0xA5, addr=7, overflow=0.
- Dropped instruction: second ready pulse 3 cycles into a MUL -> ignored; first result is written unchanged; drop_err=1 and stays 1 until reset.
- Mid-operation reset: rst_n low for one cycle during MUL EXEC -> no mem_wr_en pulse; all outputs 0. Next ADD 1+1 -> data=2 at normal latency.
